// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the SIMT block scheduler.
// Optional perf counters are enabled by defining SIMT_SCHED_PERF_EN.
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } core_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_REQUESTING  = 2'd1;
  localparam logic [1:0] LSU_WAITING     = 2'd2;

  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/pc_min_select.sv
// Minimum live-thread PC via a log-depth reduction tree,
// plus the mask of threads sitting at that PC.
module pc_min_select #(
  parameter int T  = 4,
  parameter int PA = 8
) (
  input  logic [T-1:0]         live,
  input  logic [T-1:0][PA-1:0] thread_pc,
  output logic [PA-1:0]        current_pc,
  output logic [T-1:0]         active_mask
);

  localparam int L = $clog2(T);
  localparam int P = 1 << L;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [PA-1:0] pc  [N];
    logic          vld [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < T) begin : g_thr
          assign pc[k]  = thread_pc[k];
          assign vld[k] = live[k];
        end else begin : g_pad
          assign pc[k]  = '0;
          assign vld[k] = 1'b0;
        end
      end else begin : g_cmp
        logic [PA-1:0] a, b;
        logic          va, vb, pick_a;
        assign a      = g_lvl[l-1].pc[2*k];
        assign b      = g_lvl[l-1].pc[2*k+1];
        assign va     = g_lvl[l-1].vld[2*k];
        assign vb     = g_lvl[l-1].vld[2*k+1];
        assign pick_a = va && (!vb || a <= b);
        assign pc[k]  = pick_a ? a : b;
        assign vld[k] = va | vb;
      end
    end
  end

  assign current_pc = g_lvl[L].vld[0] ? g_lvl[L].pc[0] : '0;

  for (genvar i = 0; i < T; i++) begin : g_mask
    assign active_mask[i] = live[i] && (thread_pc[i] == current_pc);
  end

endmodule

// File: rtl/simt_scheduler.sv
// Per-block SIMT sequencer: min-PC issue with automatic reconvergence.
// Define SIMT_SCHED_PERF_EN to build the saturating perf counters.
module simt_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int PROG_MEM_ADDR_BITS = 8,
  parameter int PERF_CNT_BITS      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
  input  logic [2:0]           fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0] lsu_state,
  input  logic                 dec_ret,
  input  logic [THREADS_PER_BLOCK-1:0][PROG_MEM_ADDR_BITS-1:0] next_pc,
  output logic [2:0]           core_state,
  output logic [PROG_MEM_ADDR_BITS-1:0] current_pc,
  output logic [THREADS_PER_BLOCK-1:0] active_mask,
  output logic                 complete,
  output logic [PERF_CNT_BITS-1:0] perf_cycles,
  output logic [PERF_CNT_BITS-1:0] perf_instrs
);

  localparam int T  = THREADS_PER_BLOCK;
  localparam int PA = PROG_MEM_ADDR_BITS;
  localparam int CW = $clog2(T) + 1;

  core_state_t state_q, state_d;
  logic [T-1:0]         live_q;
  logic [T-1:0][PA-1:0] pc_q;
  logic [CW-1:0]        n_eff;
  logic [T-1:0]         live_init;
  logic [T-1:0]         ret_mask;
  logic                 mem_busy;
  logic                 last_ret;
  logic                 launch;

  pc_min_select #(.T(T), .PA(PA)) u_min (
    .live        (live_q),
    .thread_pc   (pc_q),
    .current_pc  (current_pc),
    .active_mask (active_mask)
  );

  assign n_eff = (thread_count > CW'(T)) ? CW'(T) : thread_count;
  assign launch = (state_q == S_IDLE) && start;
  assign ret_mask = active_mask & {T{dec_ret}};
  assign last_ret = ((live_q & ~ret_mask) == '0);

  always_comb begin
    live_init = '0;
    mem_busy  = 1'b0;
    for (int i = 0; i < T; i++) begin
      live_init[i] = (i < int'(n_eff));
      if (active_mask[i] && lsu_busy(lsu_state[i]))
        mem_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (n_eff == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (fetcher_state == FETCHER_FETCHED)
          state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:
        if (!mem_busy) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE:
        state_d = last_ret ? S_DONE : S_FETCH;
      S_DONE:
        if (!start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Only threads at the issue PC retire or advance; others wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= '0;
      pc_q   <= '0;
    end else if (launch) begin
      live_q <= live_init;
      pc_q   <= '0;
    end else if (state_q == S_UPDATE) begin
      for (int i = 0; i < T; i++) begin
        if (active_mask[i]) begin
          if (dec_ret) live_q[i] <= 1'b0;
          else         pc_q[i]   <= next_pc[i];
        end
      end
    end
  end

  assign core_state = state_q;
  assign complete   = (state_q == S_DONE);

`ifdef SIMT_SCHED_PERF_EN
  logic [PERF_CNT_BITS-1:0] cyc_q, ins_q;
  logic run_cycle;

  assign run_cycle = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (launch) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (run_cycle && cyc_q != '1)
        cyc_q <= cyc_q + 1'b1;
      if (state_q == S_DECODE && ins_q != '1)
        ins_q <= ins_q + 1'b1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_instrs = ins_q;
`else
  assign perf_cycles = '0;
  assign perf_instrs = '0;
`endif

endmodule
